neosd_cmd_seq: RTL and testbench

Command sequencer in front of the NeoSD SD-card command-line FSM.
- Accepts one command descriptor from the host: index, argument, response mode and data mode.
- Computes the CRC7 bit-serially and loads the FSM's shift register, then starts the FSM.
- Drains each response word through a valid/ready stream, acknowledging the FSM word by word, and signals completion.
- Removes all CRC and handshake sequencing from software.

---
 rtl/neosd_pkg.sv | 31 +++
 rtl/neosd_crc7.sv | 31 +++
 rtl/neosd_cmd_seq.sv | 188 ++++++++++++++++++
 tb/tb_neosd_cmd_seq.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neosd_pkg.sv
// Shared types and constants for the NeoSD command path (sequencer, command FSM, CRC units).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package neosd_pkg;

    // Response length requested from the card; encoding shared with the command FSM.
    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_SHORT = 2'd1,
        RESP_LONG  = 2'd2
    } resp_mode_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CRC,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_RESP,
        ST_OUT,
        ST_ACK,
        ST_WAIT_IDLE
    } seq_state_t;

    // x^7 + x^3 + 1, top term implicit.
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Start bit, transmission bit, 6-bit index, 32-bit argument.
    localparam int FRAME_BITS = 40;

endpackage

// File: rtl/neosd_crc7.sv
// Bit-serial CRC7 (x^7+x^3+1), MSB-first input, register cleared to 0.
// Latency: one bit per enabled clk_i; crc_o reflects all bits fed so far.
// Backpressure: none; en_i gates the shift.
// Ports: clk_i/rstn_i clock and async reset, clr_i synchronous clear,
//        en_i shift enable, bit_i serial data bit, crc_o current remainder.
module neosd_crc7
    import neosd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic fb;

    assign fb = crc_o[6] ^ bit_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            crc_o <= '0;
        end else if (clr_i) begin
            crc_o <= '0;
        end else if (en_i) begin
            crc_o <= {crc_o[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/neosd_cmd_seq.sv
// Command sequencer: takes one descriptor, computes CRC7, loads and starts the SD command FSM, drains its response.
// Latency: 40 CRC cycles + LOAD + START (each stretched to the next clkstrb_i) until the FSM is started.
// Backpressure: req_ready_o low while busy; each response word is held on rsp_* until rsp_ready_i, ack follows acceptance.
// Ports: req_* host descriptor (valid/ready), rsp_* response stream (valid/ready, last),
//        busy_o/done_o status, cmd_*/ctrl_* drive the command FSM, fsm_*/resp_data_i its status and data.
module neosd_cmd_seq
    import neosd_pkg::*;
#(
    parameter int SHORT_WORDS = 2,
    parameter int LONG_WORDS  = 5
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        clkstrb_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [5:0]  req_idx_i,
    input  logic [31:0] req_arg_i,
    input  logic [1:0]  req_rmode_i,
    input  logic [1:0]  req_dmode_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_last_o,
    input  logic        rsp_ready_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [5:0]  cmd_idx_o,
    output logic        cmd_idx_load_o,
    output logic [31:0] cmd_arg_o,
    output logic [3:0]  cmd_arg_load_o,
    output logic [6:0]  cmd_crc_o,
    output logic        cmd_crc_load_o,
    output logic        ctrl_start_o,
    output logic        ctrl_resp_ack_o,
    output logic [1:0]  ctrl_rmode_o,
    output logic [1:0]  ctrl_dmode_o,
    input  logic        fsm_idle_i,
    input  logic        fsm_resp_i,
    input  logic [31:0] resp_data_i
);

    localparam int MAX_WORDS = (SHORT_WORDS > LONG_WORDS) ? SHORT_WORDS : LONG_WORDS;
    localparam int WC_W      = $clog2(MAX_WORDS + 1);

    seq_state_t        state;
    logic [5:0]        idx_q;
    logic [31:0]       arg_q;
    logic [1:0]        rmode_q;
    logic [1:0]        dmode_q;
    logic [5:0]        bit_cnt;
    logic [WC_W-1:0]   word_cnt;
    logic [39:0]       frame;
    logic              crc_clr;
    logic              crc_en;
    logic              crc_bit;
    logic [6:0]        crc;

    // rmode 3 is not a valid response length and falls into the no-response case.
    function automatic logic [WC_W-1:0] words_for(input logic [1:0] m);
        case (m)
            2'(RESP_SHORT): return WC_W'(SHORT_WORDS);
            2'(RESP_LONG):  return WC_W'(LONG_WORDS);
            default:        return '0;
        endcase
    endfunction

    assign frame       = {2'b01, idx_q, arg_q};
    assign req_ready_o = (state == ST_IDLE) && fsm_idle_i;
    assign busy_o      = (state != ST_IDLE);
    assign crc_clr     = req_valid_i && req_ready_o;
    assign crc_en      = (state == ST_CRC);
    assign crc_bit     = frame[6'd39 - bit_cnt];

    assign cmd_idx_o    = idx_q;
    assign cmd_arg_o    = arg_q;
    assign cmd_crc_o    = crc;
    assign ctrl_rmode_o = rmode_q;
    assign ctrl_dmode_o = dmode_q;

    neosd_crc7 u_crc7 (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .clr_i  (crc_clr),
        .en_i   (crc_en),
        .bit_i  (crc_bit),
        .crc_o  (crc)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= ST_IDLE;
            idx_q           <= '0;
            arg_q           <= '0;
            rmode_q         <= '0;
            dmode_q         <= '0;
            bit_cnt         <= '0;
            word_cnt        <= '0;
            rsp_valid_o     <= 1'b0;
            rsp_data_o      <= '0;
            rsp_last_o      <= 1'b0;
            done_o          <= 1'b0;
            cmd_idx_load_o  <= 1'b0;
            cmd_arg_load_o  <= 4'h0;
            cmd_crc_load_o  <= 1'b0;
            ctrl_start_o    <= 1'b0;
            ctrl_resp_ack_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        idx_q   <= req_idx_i;
                        arg_q   <= req_arg_i;
                        rmode_q <= req_rmode_i;
                        dmode_q <= req_dmode_i;
                        bit_cnt <= '0;
                        state   <= ST_CRC;
                    end
                end
                // Runs on every clk_i; the strobe only paces the FSM handshakes.
                ST_CRC: begin
                    bit_cnt <= bit_cnt + 6'd1;
                    if (bit_cnt == 6'(FRAME_BITS - 1)) begin
                        cmd_idx_load_o <= 1'b1;
                        cmd_arg_load_o <= 4'hF;
                        cmd_crc_load_o <= 1'b1;
                        state          <= ST_LOAD;
                    end
                end
                // The FSM samples only on strobe cycles, so each request is held through one.
                ST_LOAD: begin
                    if (clkstrb_i) begin
                        cmd_idx_load_o <= 1'b0;
                        cmd_arg_load_o <= 4'h0;
                        cmd_crc_load_o <= 1'b0;
                        ctrl_start_o   <= 1'b1;
                        state          <= ST_START;
                    end
                end
                ST_START: begin
                    if (clkstrb_i) begin
                        ctrl_start_o <= 1'b0;
                        word_cnt     <= words_for(rmode_q);
                        state        <= ST_WAIT_BUSY;
                    end
                end
                // Idle dropping confirms the FSM took the start before we look at its status.
                ST_WAIT_BUSY: begin
                    if (!fsm_idle_i) begin
                        state <= (word_cnt == '0) ? ST_WAIT_IDLE : ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (fsm_resp_i) begin
                        rsp_data_o  <= resp_data_i;
                        rsp_valid_o <= 1'b1;
                        rsp_last_o  <= (word_cnt == WC_W'(1));
                        state       <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o     <= 1'b0;
                        rsp_last_o      <= 1'b0;
                        word_cnt        <= word_cnt - WC_W'(1);
                        ctrl_resp_ack_o <= 1'b1;
                        state           <= ST_ACK;
                    end
                end
                // fsm_resp_i is not looked at here: the FSM clears it on the same strobe.
                ST_ACK: begin
                    if (clkstrb_i) begin
                        ctrl_resp_ack_o <= 1'b0;
                        state <= (word_cnt != '0) ? ST_WAIT_RESP : ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (fsm_idle_i) begin
                        done_o <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neosd_cmd_seq.sv
module tb_neosd_cmd_seq;

    localparam int SW = 2;
    localparam int LW = 5;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        clkstrb_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [5:0]  req_idx_i;
    logic [31:0] req_arg_i;
    logic [1:0]  req_rmode_i;
    logic [1:0]  req_dmode_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_last_o;
    logic        rsp_ready_i;
    logic        busy_o;
    logic        done_o;
    logic [5:0]  cmd_idx_o;
    logic        cmd_idx_load_o;
    logic [31:0] cmd_arg_o;
    logic [3:0]  cmd_arg_load_o;
    logic [6:0]  cmd_crc_o;
    logic        cmd_crc_load_o;
    logic        ctrl_start_o;
    logic        ctrl_resp_ack_o;
    logic [1:0]  ctrl_rmode_o;
    logic [1:0]  ctrl_dmode_o;
    logic        fsm_idle_i;
    logic        fsm_resp_i;
    logic [31:0] resp_data_i;

    always #5 clk_i = ~clk_i;

    neosd_cmd_seq #(.SHORT_WORDS(SW), .LONG_WORDS(LW)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .clkstrb_i(clkstrb_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_idx_i(req_idx_i),
        .req_arg_i(req_arg_i), .req_rmode_i(req_rmode_i), .req_dmode_i(req_dmode_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o),
        .rsp_ready_i(rsp_ready_i), .busy_o(busy_o), .done_o(done_o),
        .cmd_idx_o(cmd_idx_o), .cmd_idx_load_o(cmd_idx_load_o), .cmd_arg_o(cmd_arg_o),
        .cmd_arg_load_o(cmd_arg_load_o), .cmd_crc_o(cmd_crc_o), .cmd_crc_load_o(cmd_crc_load_o),
        .ctrl_start_o(ctrl_start_o), .ctrl_resp_ack_o(ctrl_resp_ack_o),
        .ctrl_rmode_o(ctrl_rmode_o), .ctrl_dmode_o(ctrl_dmode_o),
        .fsm_idle_i(fsm_idle_i), .fsm_resp_i(fsm_resp_i), .resp_data_i(resp_data_i)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // CRC7 as the remainder of polynomial long division of frame*x^7 by x^7+x^3+1.
    function automatic logic [6:0] crc_ref(input logic [39:0] frame);
        logic [46:0] v;
        v = {frame, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        end
        return v[6:0];
    endfunction

    function automatic int beats_for(input logic [1:0] rm);
        return (rm == 2'd1) ? SW : (rm == 2'd2) ? LW : 0;
    endfunction

    // ---------------- command FSM model (acts on strobe cycles only) ----------------
    logic [31:0] words [5];
    int m_phase, m_cnt, m_left, m_widx;
    logic m_data;

    always @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fsm_idle_i  <= 1'b1;
            fsm_resp_i  <= 1'b0;
            resp_data_i <= '0;
            m_phase <= 0; m_cnt <= 0; m_left <= 0; m_widx <= 0; m_data <= 1'b0;
        end else if (clkstrb_i) begin
            case (m_phase)
                0: if (ctrl_start_o) begin
                    fsm_idle_i <= 1'b0;
                    m_left  <= beats_for(ctrl_rmode_o);
                    m_data  <= (ctrl_dmode_o != 2'd0);
                    m_widx  <= 0;
                    m_cnt   <= 6;
                    m_phase <= 1;
                end
                1: if (m_cnt == 0) begin
                    if (m_left > 0) begin
                        fsm_resp_i <= 1'b1; resp_data_i <= words[m_widx]; m_phase <= 2;
                    end else begin
                        m_cnt <= 8; m_phase <= 4;
                    end
                end else m_cnt <= m_cnt - 1;
                2: if (ctrl_resp_ack_o) begin
                    fsm_resp_i  <= 1'b0;
                    resp_data_i <= 32'hDEADBEEF;
                    m_left <= m_left - 1;
                    m_widx <= m_widx + 1;
                    if (m_left == 1) begin
                        if (m_data) begin fsm_idle_i <= 1'b1; m_phase <= 0; end
                        else begin m_cnt <= 8; m_phase <= 4; end
                    end else begin
                        m_cnt <= 3; m_phase <= 3;
                    end
                end
                3: if (m_cnt == 0) begin
                    fsm_resp_i <= 1'b1; resp_data_i <= words[m_widx]; m_phase <= 2;
                end else m_cnt <= m_cnt - 1;
                4: if (m_cnt == 0) begin
                    fsm_idle_i <= 1'b1; m_phase <= 0;
                end else m_cnt <= m_cnt - 1;
                default: m_phase <= 0;
            endcase
        end
    end

    // ---------------- strobe/ready drive and protocol monitor ----------------
    int period = 1;
    int ready_pct = 100;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic p_load, p_start, p_ack, p_strb, p_valid, p_ready, p_hs;
    logic [31:0] p_data;
    logic hs;
    int n_load, n_start, n_ack, n_done, n_beats, n_last, exp_beats, acc_cyc;
    logic [6:0]  cap_crc;
    logic [5:0]  cap_idx;
    logic [31:0] cap_arg;
    logic [3:0]  cap_argld;
    logic [1:0]  cap_rm, cap_dm;
    logic [31:0] exp_q [$];

    always @(negedge clk_i) begin
        cyc++;
        clkstrb_i   = ((cyc % period) == 0);
        rsp_ready_i = ($urandom_range(99) < ready_pct);
        hs = rsp_valid_o && rsp_ready_i;
        if (mon_en && rstn_i) begin
            if (req_valid_i && req_ready_o) acc_cyc = cyc;
            if (cmd_idx_load_o && !p_load) chk("crc_latency", cyc - acc_cyc, 41);
            if (p_load)  chk("load_hold", {cmd_idx_load_o, cmd_arg_load_o, cmd_crc_load_o}, p_strb ? 6'h00 : 6'h3F);
            if (p_start) chk("start_hold", ctrl_start_o, !p_strb);
            if (p_ack)   chk("ack_hold", ctrl_resp_ack_o, !p_strb);
            if (ctrl_start_o) chk("load_start_excl", {cmd_idx_load_o, cmd_arg_load_o, cmd_crc_load_o}, 6'h00);
            if (ctrl_resp_ack_o && !p_ack) chk("ack_after_accept", p_hs, 1);
            if (p_valid && !p_ready) begin
                chk("stall_valid", rsp_valid_o, 1);
                chk("stall_data", rsp_data_o, p_data);
            end
            if (cmd_idx_load_o && clkstrb_i) begin
                n_load++;
                cap_crc = cmd_crc_o; cap_idx = cmd_idx_o; cap_arg = cmd_arg_o; cap_argld = cmd_arg_load_o;
            end
            if (ctrl_start_o && clkstrb_i) begin
                n_start++; cap_rm = ctrl_rmode_o; cap_dm = ctrl_dmode_o;
            end
            if (ctrl_resp_ack_o && clkstrb_i) n_ack++;
            if (done_o) n_done++;
            if (hs) begin
                n_beats++;
                if (rsp_last_o) n_last++;
                if (exp_q.size() > 0) chk("beat_data", rsp_data_o, exp_q.pop_front());
                chk("beat_last", rsp_last_o, n_beats == exp_beats);
            end
            p_load = cmd_idx_load_o; p_start = ctrl_start_o; p_ack = ctrl_resp_ack_o;
            p_strb = clkstrb_i; p_valid = rsp_valid_o; p_ready = rsp_ready_i;
            p_hs = hs; p_data = rsp_data_o;
        end else begin
            p_load = 0; p_start = 0; p_ack = 0; p_strb = 0; p_valid = 0; p_ready = 0; p_hs = 0; p_data = 0;
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [1:0]  rmode;
        logic [1:0]  dmode;
        int          period;
        int          ready_pct;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [6:0]  exp_crc;
        int          exp_beats;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rm,
                                input logic [1:0] dm, input int per, input int rdy,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [6:0] crc, input int nb);
        vec_t v;
        v.idx = idx; v.arg = arg; v.rmode = rm; v.dmode = dm; v.period = per; v.ready_pct = rdy;
        v.w0 = w0; v.w1 = w1; v.exp_crc = crc; v.exp_beats = nb;
        return v;
    endfunction

    task automatic prep(input vec_t v);
        period = v.period; ready_pct = v.ready_pct;
        words[0] = v.w0; words[1] = v.w1;
        for (int k = 2; k < 5; k++) words[k] = $urandom;
        exp_beats = v.exp_beats;
        exp_q.delete();
        for (int k = 0; k < v.exp_beats; k++) exp_q.push_back(words[k]);
        n_load = 0; n_start = 0; n_ack = 0; n_done = 0; n_beats = 0; n_last = 0;
        cap_crc = 'x; cap_idx = 'x; cap_arg = 'x; cap_argld = 'x; cap_rm = 'x; cap_dm = 'x;
    endtask

    task automatic issue(input vec_t v);
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(posedge clk_i); #2;
            ok = req_ready_o;
        end
        chk("req_ready_wait", ok, 1);
        req_valid_i = 1'b1; req_idx_i = v.idx; req_arg_i = v.arg;
        req_rmode_i = v.rmode; req_dmode_i = v.dmode;
        @(posedge clk_i); #2;
        // Garbage on the descriptor while busy must not disturb the latched command.
        req_valid_i = 1'b0; req_idx_i = ~v.idx; req_arg_i = ~v.arg;
        req_rmode_i = ~v.rmode; req_dmode_i = ~v.dmode;
        chk("busy_after_accept", {busy_o, req_ready_o}, 2'b10);
    endtask

    task automatic run_cmd(input vec_t v);
        bit ok;
        prep(v);
        issue(v);
        ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(posedge clk_i); #2;
            ok = (n_done > 0);
        end
        chk("done_timeout", ok, 1);
        @(posedge clk_i); #2;
        chk("crc", cap_crc, v.exp_crc);
        chk("load_idx", cap_idx, v.idx);
        chk("load_arg", cap_arg, v.arg);
        chk("load_argbytes", cap_argld, 4'hF);
        chk("rmode_at_start", cap_rm, v.rmode);
        chk("dmode_at_start", cap_dm, v.dmode);
        chk("n_load", n_load, 1);
        chk("n_start", n_start, 1);
        chk("n_beats", n_beats, v.exp_beats);
        chk("n_ack", n_ack, v.exp_beats);
        chk("n_last", n_last, (v.exp_beats > 0) ? 1 : 0);
        chk("words_left", exp_q.size(), 0);
        chk("n_done", n_done, 1);
        chk("idle_after", {req_ready_o, busy_o, done_o, rsp_valid_o}, 4'b1000);
    endtask

    vec_t vecs [6];

    initial begin
        vec_t rv;
        bit ok;
        rstn_i = 1'b0; req_valid_i = 1'b0; req_idx_i = '0; req_arg_i = '0;
        req_rmode_i = '0; req_dmode_i = '0;
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_ready", req_ready_o, 1);
        chk("rst_ctl", {busy_o, done_o, rsp_valid_o, rsp_last_o, ctrl_start_o, ctrl_resp_ack_o,
                        cmd_idx_load_o, cmd_arg_load_o, cmd_crc_load_o, ctrl_rmode_o, ctrl_dmode_o}, '0);
        chk("rst_data", {rsp_data_o, cmd_arg_o}, '0);
        chk("rst_cmd", {cmd_idx_o, cmd_crc_o}, '0);
        rstn_i = 1'b1;
        mon_en = 1'b1;

        vecs[0] = mk(6'd0,  32'h0,        2'd0, 2'd0, 1, 100, 32'h0,        32'h0,        7'h4A, 0);
        vecs[1] = mk(6'd8,  32'h000001AA, 2'd1, 2'd0, 1, 100, 32'h00000801, 32'h000001AA, 7'h43, 2);
        vecs[2] = mk(6'd17, 32'h0,        2'd1, 2'd1, 1, 100, 32'h11000900, 32'h00000900, 7'h2A, 2);
        vecs[3] = mk(6'd2,  32'h0,        2'd2, 2'd0, 1, 40,  32'h0000003F, 32'h12345678, 7'h26, 5);
        vecs[4] = mk(6'd55, 32'h0,        2'd1, 2'd0, 4, 100, 32'h00003700, 32'h00000120, 7'h32, 2);
        vecs[5] = mk(6'd41, 32'h40000000, 2'd3, 2'd0, 2, 100, 32'h0,        32'h0,        7'h3B, 0);
        foreach (vecs[i]) run_cmd(vecs[i]);

        for (int i = 0; i < 8; i++) begin
            rv.idx = 6'($urandom_range(63)); rv.arg = $urandom;
            rv.rmode = 2'($urandom_range(3)); rv.dmode = 2'($urandom_range(3));
            rv.period = $urandom_range(1, 4); rv.ready_pct = $urandom_range(30, 100);
            rv.w0 = $urandom; rv.w1 = $urandom;
            rv.exp_crc = crc_ref({2'b01, rv.idx, rv.arg});
            rv.exp_beats = beats_for(rv.rmode);
            run_cmd(rv);
        end

        // Reset while a response word is stalled in front of the host.
        rv = vecs[3];
        rv.period = 2; rv.ready_pct = 0;
        prep(rv);
        issue(rv);
        ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(posedge clk_i); #2;
            ok = rsp_valid_o;
        end
        chk("rst_reach_out", ok, 1);
        repeat (3) @(posedge clk_i);
        #2;
        mon_en = 1'b0;
        rstn_i = 1'b0;
        #1;
        chk("midrst_ready", req_ready_o, 1);
        chk("midrst_ctl", {busy_o, done_o, rsp_valid_o, rsp_last_o, ctrl_start_o, ctrl_resp_ack_o,
                           cmd_idx_load_o, cmd_arg_load_o, cmd_crc_load_o, ctrl_rmode_o, ctrl_dmode_o}, '0);
        chk("midrst_data", {rsp_data_o, cmd_arg_o}, '0);
        chk("midrst_cmd", {cmd_idx_o, cmd_crc_o}, '0);
        @(posedge clk_i); #2;
        rstn_i = 1'b1;
        mon_en = 1'b1;
        run_cmd(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
